// File: rtl/timer_top.sv
// -----------------------------------------------------------------------------
// timer_top
//
// Memory-mapped timer on the CPU data bus. It decodes a 6-register window at
// BASE_ADDR, takes full-word writes from the load/store stage and drives the
// shared read bus combinationally while selected for a read. The timer is a
// prescaled 32-bit up-counter with a compare register, a sticky match flag and
// a level interrupt.
//
// Register map (word offsets from BASE_ADDR):
//   0x00 CTRL      bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN
//   0x04 PRESCALE  [15:0]
//   0x08 COUNT     [31:0] read/write
//   0x0C CMP       [31:0] read/write
//   0x10 STATUS    bit0 MATCH, sticky, write 1 to clear
//   0x14 PCNT      [15:0] current prescaler count, read-only
//
// Optional feature macro: TIMER_PRESCALER_EN
//   defined   : PRESCALE/PCNT are live and the counter advances every
//               PRESCALE+1 cycles.
//   undefined : no prescaler; COUNT advances every cycle while EN=1, and
//               offsets 0x04/0x14 read 0 and ignore writes.
//
// Ports:
//   CLK     in   core clock
//   HRESET  in   synchronous active-low reset
//   HWRITE  in   1 = write cycle, 0 = read cycle
//   PADDR   in   [31:0] physical address
//   PWDATA  in   [31:0] write data
//   PRDATA  out  [31:0] shared read bus, high-Z unless selected for a read
//   IRQ     out  level interrupt = MATCH & IRQ_EN
// -----------------------------------------------------------------------------
module timer_top #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_2000
) (
    input  logic        CLK,
    input  logic        HRESET,
    input  logic        HWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        IRQ
);

    typedef enum logic [2:0] {
        OFF_CTRL     = 3'd0,
        OFF_PRESCALE = 3'd1,
        OFF_COUNT    = 3'd2,
        OFF_CMP      = 3'd3,
        OFF_STATUS   = 3'd4,
        OFF_PCNT     = 3'd5
    } reg_off_e;

    // Byte lanes are not supported; the low address bits are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, PADDR[1:0]};

    reg_off_e   off;
    logic       sel;
    logic       wr;
    logic       wr_ctrl;
    logic       wr_prescale;
    logic       wr_count;
    logic       wr_cmp;
    logic       wr_status;

    assign off = reg_off_e'(PADDR[4:2]);
    assign sel = (PADDR[31:5] == BASE_ADDR[31:5]) && (PADDR[4:2] <= 3'd5);
    assign wr  = sel && HWRITE;

    assign wr_ctrl     = wr && (off == OFF_CTRL);
    assign wr_prescale = wr && (off == OFF_PRESCALE);
    assign wr_count    = wr && (off == OFF_COUNT);
    assign wr_cmp      = wr && (off == OFF_CMP);
    assign wr_status   = wr && (off == OFF_STATUS);

    logic        en;
    logic        autoreload;
    logic        irq_en;
    logic [31:0] count;
    logic [31:0] cmp;
    logic        match;
    logic        tick;
    logic [15:0] prescale;
    logic [15:0] pcnt;

`ifdef TIMER_PRESCALER_EN
    assign tick = en && (pcnt == prescale);

    // A PRESCALE write restarts the prescaler so the new period starts cleanly.
    always_ff @(posedge CLK) begin
        if (!HRESET) begin
            prescale <= '0;
            pcnt     <= '0;
        end else begin
            if (wr_prescale) begin
                prescale <= PWDATA[15:0];
            end
            if (wr_prescale || tick) begin
                pcnt <= '0;
            end else if (en) begin
                pcnt <= pcnt + 16'd1;
            end
        end
    end
`else
    assign tick     = en;
    assign prescale = '0;
    assign pcnt     = '0;
`endif

    // A bus write to COUNT overrides the tick, including its compare.
    logic hit;
    assign hit = tick && !wr_count && (count == cmp);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, matching the hardware.
    always_ff @(posedge CLK) begin
        if (!HRESET) begin
            en         <= 1'b0;
            autoreload <= 1'b0;
            irq_en     <= 1'b0;
            count      <= '0;
            cmp        <= 32'hFFFF_FFFF;
            match      <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en         <= PWDATA[0];
                autoreload <= PWDATA[1];
                irq_en     <= PWDATA[2];
            end

            if (wr_cmp) begin
                cmp <= PWDATA;
            end

            // Increment wraps silently at 0xFFFF_FFFF.
            if (wr_count) begin
                count <= PWDATA;
            end else if (hit && autoreload) begin
                count <= '0;
            end else if (tick) begin
                count <= count + 32'd1;
            end

            // Set beats a same-cycle write-1-to-clear.
            if (hit) begin
                match <= 1'b1;
            end else if (wr_status && PWDATA[0]) begin
                match <= 1'b0;
            end
        end
    end

    assign IRQ = match & irq_en;

    logic [31:0] rdata;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:     rdata = {29'd0, irq_en, autoreload, en};
            OFF_PRESCALE: rdata = {16'd0, prescale};
            OFF_COUNT:    rdata = count;
            OFF_CMP:      rdata = cmp;
            OFF_STATUS:   rdata = {31'd0, match};
            OFF_PCNT:     rdata = {16'd0, pcnt};
            default:      rdata = '0;
        endcase
    end

    // Other responders share this bus, so release it unless selected for a read.
    assign PRDATA = (sel && !HWRITE) ? rdata : {32{1'bz}};

endmodule
